// File: rtl/reg_pkg.sv
// Shared definitions for the SPI register file and any future serial peripheral.
// REGCOUNT is a global define so the register bank and its consumers agree on size.
`ifndef REGCOUNT
`define REGCOUNT 8
`endif

package reg_pkg;

    // Register 0 always answers with the ID value and cannot be written.
    localparam logic [6:0] REG_ID = 7'h00;

    // Position of the read/write flag inside the command byte (1 = read).
    localparam int RW_BIT = 7;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for the SPI pins plus single-cycle sclk edge pulses.
// cs_n resets to 0 (looks selected) so that a frame already in progress when
// reset is released is not picked up half-way: the owner must first see cs_n high.
module spi_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [1:0] sclk_ff;
    logic [1:0] cs_n_ff;
    logic [1:0] mosi_ff;
    logic       sclk_d;

    // Synchronize the asynchronous pins and keep one delayed copy of sclk for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_ff <= 2'b00;
            cs_n_ff <= 2'b00;
            mosi_ff <= 2'b00;
            sclk_d  <= 1'b0;
        end else begin
            sclk_ff <= {sclk_ff[0], sclk};
            cs_n_ff <= {cs_n_ff[0], cs_n};
            mosi_ff <= {mosi_ff[0], mosi};
            sclk_d  <= sclk_ff[1];
        end
    end

    assign cs_n_s    = cs_n_ff[1];
    assign mosi_s    = mosi_ff[1];
    assign sclk_rise = sclk_ff[1] & ~sclk_d;
    assign sclk_fall = ~sclk_ff[1] & sclk_d;

endmodule

// File: rtl/spi_reg_file.sv
// SPI mode-0 slave with an auto-incrementing byte register bank.
// Register 0 is a read-only ID; address wrap skips it so bursts stay in writable space.
// registers_packed is a registered copy of the bank that drives the IO/PWM stage.
import reg_pkg::*;

module spi_reg_file #(
    parameter int         REGCOUNT = `REGCOUNT,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic [8*REGCOUNT-1:0] registers_packed,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr
);

    logic       cs_n_s;
    logic       mosi_s;
    logic       sclk_rise;
    logic       sclk_fall;

    spi_state_t state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [6:0] addr;
    logic       rw;
    logic       armed;
    logic [7:0] regs [1:REGCOUNT-1];

    logic [7:0] rx_byte;
    logic [6:0] load_addr;
    logic [7:0] rd_data;

    spi_sync_edge u_sync (
        .clock     (clock),
        .reset     (reset),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    // Next burst address; wrapping lands on 1 because register 0 is the ID.
    function automatic logic [6:0] next_addr(input logic [6:0] a);
        if (a == 7'(REGCOUNT - 1)) begin
            return 7'd1;
        end
        return a + 7'd1;
    endfunction

    // Only registers 1..REGCOUNT-1 accept writes.
    function automatic logic addr_writable(input logic [6:0] a);
        return (a != REG_ID) && (int'(a) < REGCOUNT);
    endfunction

    // The byte completed by the current sclk rise.
    assign rx_byte = {rx_shift, mosi_s};

    // A read preloads the commanded address after CMD, and the following address after each DATA byte.
    assign load_addr = (state == CMD) ? rx_byte[6:0] : next_addr(addr);

    // Read mux: ID for address 0, zero for addresses beyond the bank.
    always_comb begin
        rd_data = 8'h00;
        if (load_addr == REG_ID) begin
            rd_data = ID_VALUE;
        end
        for (int i = 1; i < REGCOUNT; i++) begin
            if (load_addr == 7'(i)) begin
                rd_data = regs[i];
            end
        end
    end

    // Frame FSM, bit counter, shifters, address counter and register writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            rx_shift  <= 7'd0;
            tx_shift  <= 8'd0;
            addr      <= 7'd0;
            rw        <= 1'b0;
            armed     <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 7'd0;
            for (int i = 1; i < REGCOUNT; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            wr_strobe <= 1'b0;
            if (cs_n_s) begin
                state <= IDLE;
                armed <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state    <= CMD;
                            bit_cnt  <= 3'd0;
                            rw       <= 1'b0;
                            tx_shift <= 8'd0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw    <= rx_byte[RW_BIT];
                                addr  <= rx_byte[6:0];
                                state <= DATA;
                                if (rx_byte[RW_BIT]) begin
                                    tx_shift <= rd_data;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (rw) begin
                                    tx_shift <= rd_data;
                                end else if (addr_writable(addr)) begin
                                    for (int i = 1; i < REGCOUNT; i++) begin
                                        if (addr == 7'(i)) begin
                                            regs[i] <= rx_byte;
                                        end
                                    end
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= addr;
                                end
                                addr <= next_addr(addr);
                            end
                        end else if (sclk_fall && (bit_cnt != 3'd0)) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // miso only carries data during the data phase of a read frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miso <= 1'b0;
        end else begin
            miso <= (state == DATA) && rw && tx_shift[7] && !cs_n_s;
        end
    end

    // Registered copy of the bank for the output stage, ID in the low byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            registers_packed <= {{(8*(REGCOUNT-1)){1'b0}}, ID_VALUE};
        end else begin
            registers_packed[7:0] <= ID_VALUE;
            for (int i = 1; i < REGCOUNT; i++) begin
                registers_packed[8*i +: 8] <= regs[i];
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_file.sv
// Directed bench for spi_reg_file: an SPI master drives frames, expected writes and
// miso bytes go into queues, and monitor processes compare them as the DUT produces them.
`ifndef REGCOUNT
`define REGCOUNT 8
`endif

module tb_spi_reg_file;

    localparam int         REGCOUNT = `REGCOUNT;
    localparam int         CW       = 8 * REGCOUNT;
    localparam logic [7:0] ID_VALUE = 8'hA5;
    localparam int         HALF     = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          sclk;
    logic          cs_n;
    logic          mosi;
    logic          miso;
    logic [CW-1:0] registers_packed;
    logic          wr_strobe;
    logic [6:0]    wr_addr;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    int         n_vec  = 0;
    int         n_fail = 0;
    logic [7:0] model [REGCOUNT];
    wr_t        exp_wr [$];
    logic [7:0] exp_rd [$];
    logic [7:0] tx_data [8];
    logic       rd_valid = 1'b0;
    logic [7:0] rd_byte  = 8'h00;

    spi_reg_file #(
        .REGCOUNT (REGCOUNT),
        .ID_VALUE (ID_VALUE)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .sclk             (sclk),
        .cs_n             (cs_n),
        .mosi             (mosi),
        .miso             (miso),
        .registers_packed (registers_packed),
        .wr_strobe        (wr_strobe),
        .wr_addr          (wr_addr)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] model_packed();
        logic [CW-1:0] v;
        v      = '0;
        v[7:0] = ID_VALUE;
        for (int i = 1; i < REGCOUNT; i++) begin
            v[8*i +: 8] = model[i];
        end
        return v;
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (a == 7'd0) return ID_VALUE;
        if (int'(a) >= REGCOUNT) return 8'h00;
        return model[a];
    endfunction

    function automatic logic [6:0] model_next(input logic [6:0] a);
        if (int'(a) == REGCOUNT - 1) return 7'd1;
        return a + 7'd1;
    endfunction

    // Shift nbits of tx out MSB first, capturing miso at each rising sclk.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clock);
            sclk  = 1'b1;
            rx[i] = miso;
            repeat (HALF) @(negedge clock);
            sclk = 1'b0;
        end
    endtask

    // Full byte: the expected miso byte is queued before the transfer, then handed to the monitor.
    task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp_miso);
        logic [7:0] rx;
        exp_rd.push_back(exp_miso);
        spi_bits(tx, 8, rx);
        rd_byte  = rx;
        rd_valid = 1'b1;
        @(negedge clock);
        rd_valid = 1'b0;
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clock);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    // One complete frame: command byte then nbytes from tx_data, with expectations queued.
    task automatic applyStimulus(input logic [7:0] cmd, input int nbytes);
        logic [6:0] a;
        a = cmd[6:0];
        frame_begin();
        spi_byte(cmd, 8'h00);
        for (int k = 0; k < nbytes; k++) begin
            if (cmd[7]) begin
                spi_byte(tx_data[k], model_read(a));
            end else begin
                if (a != 7'd0 && int'(a) < REGCOUNT) begin
                    exp_wr.push_back('{addr: a, data: tx_data[k]});
                    model[a] = tx_data[k];
                end
                spi_byte(tx_data[k], 8'h00);
            end
            a = model_next(a);
        end
        frame_end();
    endtask

    // Write monitor: each strobe must match the next queued write, and the value must
    // appear on registers_packed one cycle later.
    always @(negedge clock) begin
        static logic       pend   = 1'b0;
        static int         pend_a = 0;
        static logic [7:0] pend_d = 8'h00;
        wr_t w;
        if (pend) begin
            checkOutput("packed_after_strobe", CW'(registers_packed[8*pend_a +: 8]), CW'(pend_d));
            pend = 1'b0;
        end
        if (wr_strobe) begin
            if (exp_wr.size() == 0) begin
                checkOutput("unexpected_wr_strobe_addr", CW'(wr_addr), CW'(8'hFF));
            end else begin
                w = exp_wr.pop_front();
                checkOutput("wr_addr", CW'(wr_addr), CW'(w.addr));
                pend   = 1'b1;
                pend_a = int'(w.addr);
                pend_d = w.data;
            end
        end
    end

    // miso monitor: every completed byte is compared to the next queued expectation.
    always @(posedge clock) begin
        if (rd_valid) begin
            if (exp_rd.size() == 0) begin
                checkOutput("unexpected_miso_byte", CW'(rd_byte), CW'(9'h100));
            end else begin
                checkOutput("miso_byte", CW'(rd_byte), CW'(exp_rd.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] dummy;
        for (int i = 0; i < REGCOUNT; i++) model[i] = 8'h00;
        reset = 1'b1;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);

        // 1: reset state
        checkOutput("reset_packed", registers_packed, CW'(8'hA5));
        checkOutput("reset_miso", CW'(miso), CW'(1'b0));
        checkOutput("reset_wr_strobe", CW'(wr_strobe), CW'(1'b0));

        // 2: single write to reg1
        tx_data[0] = 8'h3C;
        applyStimulus(8'h01, 1);
        checkOutput("reg1", CW'(registers_packed[15:8]), CW'(8'h3C));

        // 3: burst write of a 16-bit field plus one more byte
        tx_data[0] = 8'h10; tx_data[1] = 8'h27; tx_data[2] = 8'h01;
        applyStimulus(8'h02, 3);
        checkOutput("pwm1_regs2to4", CW'(registers_packed[39:16]), CW'(24'h012710));

        // 4: read ID then reg1; no strobes expected
        tx_data[0] = 8'h00; tx_data[1] = 8'h00;
        applyStimulus(8'h80, 2);

        // 5: burst write across the wrap point, then read back across it
        tx_data[0] = 8'hAA; tx_data[1] = 8'h55;
        applyStimulus(8'(8'h00 | (REGCOUNT - 1)), 2);
        checkOutput("wrap_packed", registers_packed, model_packed());
        checkOutput("wrap_reg0_id", CW'(registers_packed[7:0]), CW'(8'hA5));
        tx_data[0] = 8'h00; tx_data[1] = 8'h00;
        applyStimulus(8'(8'h80 | (REGCOUNT - 1)), 2);

        // 6: abort after 5 bits of a data byte, then a normal frame
        frame_begin();
        spi_byte(8'h06, 8'h00);
        spi_bits(8'h99, 5, dummy);
        frame_end();
        checkOutput("abort_reg6", CW'(registers_packed[55:48]), CW'(8'h00));
        tx_data[0] = 8'h77;
        applyStimulus(8'h06, 1);
        checkOutput("after_abort_reg6", CW'(registers_packed[55:48]), CW'(8'h77));

        // 7: reset in the middle of a burst
        frame_begin();
        spi_byte(8'h02, 8'h00);
        exp_wr.push_back('{addr: 7'd2, data: 8'h11});
        model[2] = 8'h11;
        spi_byte(8'h11, 8'h00);
        spi_bits(8'h22, 3, dummy);
        reset = 1'b1;
        #1;
        for (int i = 0; i < REGCOUNT; i++) model[i] = 8'h00;
        checkOutput("midreset_packed", registers_packed, CW'(8'hA5));
        checkOutput("midreset_wr_strobe", CW'(wr_strobe), CW'(1'b0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        spi_bits(8'h22, 5, dummy);
        spi_byte(8'h33, 8'h00);
        frame_end();
        checkOutput("after_reset_packed", registers_packed, model_packed());
        tx_data[0] = 8'h44;
        applyStimulus(8'h03, 1);
        tx_data[0] = 8'h00;
        applyStimulus(8'h83, 1);
        checkOutput("final_packed", registers_packed, model_packed());

        repeat (10) @(negedge clock);
        checkOutput("wr_queue_empty", CW'(exp_wr.size()), CW'(0));
        checkOutput("rd_queue_empty", CW'(exp_rd.size()), CW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
